mem_lock_arbiter: RTL and testbench

- Responder side of the per-core main-memory and lock request interface in the multi-core top.
- Arbitrates core read/write requests onto the single shared main memory port and returns `main_mem_ac` per core.
- Keeps a small lock table that grants or refuses `lock_en` and `unlock_en` requests, returning `lock_ac` per core.
- Sits between the `C` core instances and `main_mem`.

---
 rtl/mem_lock_arbiter_if.sv | 36 +++
 rtl/mem_lock_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_mem_lock_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_lock_arbiter_if.sv
// Per-core memory/lock request bundle plus the arbiter's responses.
// The arbiter attaches through the slave modport. The core/memory side uses master.
interface mem_lock_arbiter_if #(
  parameter int C  = 2,
  parameter int AW = 10
);
  logic [C-1:0]    main_mem_read_request;
  logic [C-1:0]    main_mem_write_request;
  logic [C*16-1:0] main_mem_read_adr;
  logic [C*16-1:0] main_mem_write_adr;
  logic [C*16-1:0] main_mem_write_dat;
  logic [C*AW-1:0] lock_adr;
  logic [C-1:0]    lock_en;
  logic [C-1:0]    unlock_en;

  logic [C-1:0]    main_mem_ac;
  logic            mem_re;
  logic            mem_we;
  logic [15:0]     mem_adr;
  logic [15:0]     mem_wdat;
  logic [C-1:0]    lock_ac;

  modport master (
    output main_mem_read_request, main_mem_write_request,
           main_mem_read_adr, main_mem_write_adr, main_mem_write_dat,
           lock_adr, lock_en, unlock_en,
    input  main_mem_ac, mem_re, mem_we, mem_adr, mem_wdat, lock_ac
  );

  modport slave (
    input  main_mem_read_request, main_mem_write_request,
           main_mem_read_adr, main_mem_write_adr, main_mem_write_dat,
           lock_adr, lock_en, unlock_en,
    output main_mem_ac, mem_re, mem_we, mem_adr, mem_wdat, lock_ac
  );
endinterface

// File: rtl/mem_lock_arbiter.sv
// Shared main-memory arbiter and lock table for C cores.
// Memory: round-robin, one registered grant per cycle, writes win over reads
// inside a core. Locks: one operation per cycle, unlocks first, a lock request
// that cannot be granted this cycle is skipped so it never blocks others.
module mem_lock_arbiter #(
  parameter int C     = 2,
  parameter int LOCKS = 4,
  parameter int AW    = 10
) (
  input  logic              clk,
  input  logic              reset,
  mem_lock_arbiter_if.slave bus
);
  localparam int CW = (C > 1) ? $clog2(C) : 1;
  localparam int IW = (LOCKS > 1) ? $clog2(LOCKS) : 1;

  // ---------------- memory path ----------------
  logic [CW-1:0] rr_ptr;
  logic [C-1:0]  mem_ac_q;
  logic          mem_re_q;
  logic          mem_we_q;
  logic [15:0]   mem_adr_q;
  logic [15:0]   mem_wdat_q;

  logic [C-1:0]  mem_req;
  logic          mem_found;
  logic [CW-1:0] mem_sel;
  logic [C-1:0]  mem_onehot;
  logic          sel_we;
  logic [15:0]   sel_adr;
  logic [15:0]   sel_wdat;

  // Core index base+off, wrapped modulo C (off never exceeds C).
  function automatic logic [CW-1:0] wrap_idx(input logic [CW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= C) sum = sum - C;
    return CW'(sum);
  endfunction

  // Pick the first unmasked requester from the round-robin pointer and gather its bus values.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update so no latch is inferred.
    mem_req    = (bus.main_mem_read_request | bus.main_mem_write_request) & ~mem_ac_q;
    mem_found  = 1'b0;
    mem_sel    = '0;
    mem_onehot = '0;
    sel_we     = 1'b0;
    sel_adr    = '0;
    sel_wdat   = '0;
    // NOTE: blocking assignments here; mem_found must update within the same pass of the loop.
    for (int k = 0; k < C; k++) begin
      if (!mem_found && mem_req[wrap_idx(rr_ptr, k)]) begin
        mem_found = 1'b1;
        mem_sel   = wrap_idx(rr_ptr, k);
      end
    end
    for (int i = 0; i < C; i++) begin
      if (mem_found && mem_sel == CW'(i)) begin
        mem_onehot[i] = 1'b1;
        sel_we        = bus.main_mem_write_request[i];
        sel_adr       = sel_we ? bus.main_mem_write_adr[16*i +: 16]
                               : bus.main_mem_read_adr[16*i +: 16];
        sel_wdat      = sel_we ? bus.main_mem_write_dat[16*i +: 16] : 16'h0000;
      end
    end
  end

  // Register the grant and strobes; advance the pointer past the granted core.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr     <= '0;
      mem_ac_q   <= '0;
      mem_re_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_adr_q  <= '0;
      mem_wdat_q <= '0;
    end else begin
      // NOTE: non-blocking for all registered state so every flop samples pre-edge values.
      mem_ac_q   <= mem_onehot;
      mem_re_q   <= mem_found & ~sel_we;
      mem_we_q   <= mem_found & sel_we;
      mem_adr_q  <= sel_adr;
      mem_wdat_q <= sel_wdat;
      if (mem_found) rr_ptr <= wrap_idx(mem_sel, 1);
    end
  end

  // ---------------- lock path ----------------
  logic [LOCKS-1:0] lk_valid;
  logic [AW-1:0]    lk_adr   [LOCKS];
  logic [CW-1:0]    lk_owner [LOCKS];
  logic [C-1:0]     lock_ac_q;

  logic             free_any;
  logic [IW-1:0]    free_idx;
  logic [C-1:0]     hit_any;
  logic [C-1:0]     hit_own;
  logic [C-1:0]     grantable;
  logic [C-1:0]     unl_req;
  logic [C-1:0]     lck_req;
  logic             lk_found;
  logic             lk_unlock;
  logic [CW-1:0]    lk_sel;
  logic [C-1:0]     lk_onehot;
  logic [AW-1:0]    op_adr;
  logic             op_hit;
  logic [LOCKS-1:0] op_clear;
  logic             op_alloc;

  // Table lookup per core, candidate choice (unlocks first, lowest index), and the resulting edit.
  always_comb begin
    free_any  = 1'b0;
    free_idx  = '0;
    hit_any   = '0;
    hit_own   = '0;
    grantable = '0;
    for (int e = LOCKS - 1; e >= 0; e--) begin
      if (!lk_valid[e]) begin
        free_any = 1'b1;
        free_idx = IW'(e);
      end
    end
    for (int i = 0; i < C; i++) begin
      for (int e = 0; e < LOCKS; e++) begin
        if (lk_valid[e] && lk_adr[e] == bus.lock_adr[AW*i +: AW]) begin
          hit_any[i] = 1'b1;
          if (lk_owner[e] == CW'(i)) hit_own[i] = 1'b1;
        end
      end
      // Held by self: re-entrant grant. Held by another: wait. Unheld: needs a free entry.
      grantable[i] = hit_any[i] ? hit_own[i] : free_any;
    end

    unl_req   = bus.unlock_en & ~lock_ac_q;
    lck_req   = bus.lock_en & ~lock_ac_q & grantable;
    lk_found  = 1'b0;
    lk_unlock = 1'b0;
    lk_sel    = '0;
    for (int i = C - 1; i >= 0; i--) begin
      if (lck_req[i]) begin
        lk_found = 1'b1;
        lk_sel   = CW'(i);
      end
    end
    for (int i = C - 1; i >= 0; i--) begin
      if (unl_req[i]) begin
        lk_found  = 1'b1;
        lk_unlock = 1'b1;
        lk_sel    = CW'(i);
      end
    end

    lk_onehot = '0;
    op_adr    = '0;
    op_hit    = 1'b0;
    for (int i = 0; i < C; i++) begin
      if (lk_found && lk_sel == CW'(i)) begin
        lk_onehot[i] = 1'b1;
        op_adr       = bus.lock_adr[AW*i +: AW];
        op_hit       = hit_any[i];
      end
    end
    op_clear = '0;
    for (int e = 0; e < LOCKS; e++) begin
      if (lk_unlock && lk_valid[e] && lk_adr[e] == op_adr && lk_owner[e] == lk_sel)
        op_clear[e] = 1'b1;
    end
  end

  assign op_alloc = lk_found & ~lk_unlock & ~op_hit;

  // Lock acknowledge and entry valid bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lk_valid  <= '0;
      lock_ac_q <= '0;
    end else begin
      lock_ac_q <= lk_onehot;
      lk_valid  <= (lk_valid & ~op_clear) | (op_alloc ? (LOCKS'(1) << free_idx) : '0);
    end
  end

  // Entry payload written on allocation.
  // NOTE: payload needs no reset; an entry's contents are ignored while its valid bit is clear.
  always_ff @(posedge clk) begin
    if (op_alloc) begin
      lk_adr[free_idx]   <= op_adr;
      lk_owner[free_idx] <= lk_sel;
    end
  end

  assign bus.main_mem_ac = mem_ac_q;
  assign bus.mem_re      = mem_re_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_adr     = mem_adr_q;
  assign bus.mem_wdat    = mem_wdat_q;
  assign bus.lock_ac     = lock_ac_q;
endmodule

// File: tb/tb_mem_lock_arbiter.sv
// Self-checking bench for mem_lock_arbiter: directed scenarios followed by
// random traffic, all compared each cycle against a behavioural model.
module tb_mem_lock_arbiter;
  localparam int C     = 2;
  localparam int LOCKS = 4;
  localparam int AW    = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_lock_arbiter_if #(.C(C), .AW(AW)) bus ();
  mem_lock_arbiter #(.C(C), .LOCKS(LOCKS), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Core-side stimulus state
  bit            rd [C];
  bit            wr [C];
  bit            lk [C];
  bit            ul [C];
  logic [15:0]   radr [C];
  logic [15:0]   wadr [C];
  logic [15:0]   wdat [C];
  logic [AW-1:0] ladr [C];
  bit            drop_rd [C];
  bit            drop_wr [C];
  bit            drop_lk [C];
  int            lk_wait [C];
  bit            hold_mem;
  logic [AW-1:0] pool [6];

  // Reference model state
  int            m_rr;
  int            m_last_mem;
  int            m_last_lock;
  bit            m_valid [LOCKS];
  logic [AW-1:0] m_adr   [LOCKS];
  int            m_owner [LOCKS];

  logic [C-1:0]  e_ac;
  logic [C-1:0]  e_lac;
  logic          e_re;
  logic          e_we;
  logic [15:0]   e_adr;
  logic [15:0]   e_wdat;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < C; i++) begin
      bus.main_mem_read_request[i]     = rd[i];
      bus.main_mem_write_request[i]    = wr[i];
      bus.main_mem_read_adr[16*i +: 16]  = radr[i];
      bus.main_mem_write_adr[16*i +: 16] = wadr[i];
      bus.main_mem_write_dat[16*i +: 16] = wdat[i];
      bus.lock_adr[AW*i +: AW]         = ladr[i];
      bus.lock_en[i]                   = lk[i];
      bus.unlock_en[i]                 = ul[i];
    end
  endtask

  task automatic clear_inputs();
    hold_mem = 1'b0;
    for (int i = 0; i < C; i++) begin
      rd[i] = 0; wr[i] = 0; lk[i] = 0; ul[i] = 0;
      radr[i] = '0; wadr[i] = '0; wdat[i] = '0; ladr[i] = '0;
      drop_rd[i] = 0; drop_wr[i] = 0; drop_lk[i] = 0; lk_wait[i] = 0;
    end
  endtask

  task automatic model_reset();
    m_rr        = 0;
    m_last_mem  = -1;
    m_last_lock = -1;
    for (int e = 0; e < LOCKS; e++) m_valid[e] = 0;
  endtask

  function automatic int m_find(input logic [AW-1:0] a);
    for (int e = 0; e < LOCKS; e++)
      if (m_valid[e] && m_adr[e] == a) return e;
    return -1;
  endfunction

  function automatic int m_free();
    for (int e = 0; e < LOCKS; e++)
      if (!m_valid[e]) return e;
    return -1;
  endfunction

  function automatic bit m_may_lock(input int c);
    int f;
    f = m_find(ladr[c]);
    if (f >= 0) return m_owner[f] == c;
    return m_free() >= 0;
  endfunction

  // Expected outputs after the coming edge, from the inputs now applied.
  task automatic model_step();
    int sel, idx, cand, f;
    bit unl;
    e_ac = '0; e_re = 0; e_we = 0; e_adr = '0; e_wdat = '0;
    sel = -1;
    for (int k = 0; k < C; k++) begin
      idx = (m_rr + k) % C;
      if (sel < 0 && (rd[idx] || wr[idx]) && idx != m_last_mem) sel = idx;
    end
    if (sel >= 0) begin
      e_ac[sel] = 1'b1;
      if (wr[sel]) begin e_we = 1; e_adr = wadr[sel]; e_wdat = wdat[sel]; end
      else begin e_re = 1; e_adr = radr[sel]; end
      m_rr = (sel + 1) % C;
    end
    m_last_mem = sel;

    e_lac = '0;
    cand = -1;
    unl  = 0;
    for (int i = 0; i < C; i++)
      if (cand < 0 && ul[i] && i != m_last_lock) begin cand = i; unl = 1; end
    for (int i = 0; i < C; i++)
      if (cand < 0 && lk[i] && i != m_last_lock && m_may_lock(i)) cand = i;
    if (cand >= 0) begin
      e_lac[cand] = 1'b1;
      if (unl) begin
        for (int e = 0; e < LOCKS; e++)
          if (m_valid[e] && m_adr[e] == ladr[cand] && m_owner[e] == cand) m_valid[e] = 0;
      end else if (m_find(ladr[cand]) < 0) begin
        f = m_free();
        m_valid[f] = 1; m_adr[f] = ladr[cand]; m_owner[f] = cand;
      end
    end
    m_last_lock = cand;
  endtask

  task automatic check_outputs();
    check("main_mem_ac", 32'(bus.main_mem_ac), 32'(e_ac));
    check("mem_re",      32'(bus.mem_re),      32'(e_re));
    check("mem_we",      32'(bus.mem_we),      32'(e_we));
    check("mem_adr",     32'(bus.mem_adr),     32'(e_adr));
    if (e_we || e_ac == '0) check("mem_wdat", 32'(bus.mem_wdat), 32'(e_wdat));
    check("lock_ac",     32'(bus.lock_ac),     32'(e_lac));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ac"},   32'(bus.main_mem_ac), 32'h0);
    check({tag, "_re"},   32'(bus.mem_re),      32'h0);
    check({tag, "_we"},   32'(bus.mem_we),      32'h0);
    check({tag, "_adr"},  32'(bus.mem_adr),     32'h0);
    check({tag, "_wdat"}, 32'(bus.mem_wdat),    32'h0);
    check({tag, "_lac"},  32'(bus.lock_ac),     32'h0);
  endtask

  // One clock: apply inputs, predict, sample 1 time unit after the edge,
  // then let each core drop a served request one cycle after seeing its ack.
  task automatic cycle();
    apply();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
    for (int i = 0; i < C; i++) begin
      if (drop_rd[i]) rd[i] = 0;
      if (drop_wr[i]) wr[i] = 0;
      if (drop_lk[i]) begin lk[i] = 0; ul[i] = 0; end
      drop_rd[i] = 0; drop_wr[i] = 0; drop_lk[i] = 0;
      if (e_ac[i] && !hold_mem) begin
        if (e_we) drop_wr[i] = 1;
        else      drop_rd[i] = 1;
      end
      if (e_lac[i]) drop_lk[i] = 1;
    end
  endtask

  task automatic lock_op(input int c, input logic [AW-1:0] a, input bit unlock);
    ladr[c] = a;
    if (unlock) ul[c] = 1;
    else        lk[c] = 1;
    for (int n = 0; n < 8 && (lk[c] || ul[c]); n++) cycle();
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock.
  task automatic async_reset(input string tag);
    #3 reset = 1'b1;
    #1 check_idle(tag);
    model_reset();
    for (int i = 0; i < C; i++) begin
      drop_rd[i] = 0; drop_wr[i] = 0; drop_lk[i] = 0;
    end
    #1 reset = 1'b0;
  endtask

  initial begin
    pool = '{10'h3A5, 10'h001, 10'h002, 10'h003, 10'h004, 10'h005};
    clear_inputs();
    reset = 1'b1;
    apply();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    reset = 1'b0;

    // Single read from core 0, then dropped: no further grant.
    rd[0] = 1; radr[0] = 16'h0010;
    cycle();
    check("t1_ac",  32'(bus.main_mem_ac), 32'h1);
    check("t1_re",  32'(bus.mem_re),      32'h1);
    check("t1_adr", 32'(bus.mem_adr),     32'h0010);
    repeat (3) cycle();

    // Read and write together on core 1: write first, read later.
    rd[1] = 1; radr[1] = 16'h0100;
    wr[1] = 1; wadr[1] = 16'h0200; wdat[1] = 16'h1234;
    cycle();
    check("t3_we",  32'(bus.mem_we),  32'h1);
    check("t3_wadr", 32'(bus.mem_adr), 32'h0200);
    repeat (2) cycle();
    check("t3_re",  32'(bus.mem_re),  32'h1);
    check("t3_radr", 32'(bus.mem_adr), 32'h0100);
    repeat (2) cycle();

    // Both cores hold writes: grants alternate.
    hold_mem = 1;
    wr[0] = 1; wadr[0] = 16'h0001; wdat[0] = 16'hAAAA;
    wr[1] = 1; wadr[1] = 16'h0002; wdat[1] = 16'h5555;
    repeat (6) cycle();
    hold_mem = 0;
    wr[0] = 0; wr[1] = 0;
    repeat (2) cycle();

    // Lock contention and hand-over on unlock.
    lock_op(0, 10'h3A5, 0);
    lk[1] = 1; ladr[1] = 10'h3A5;
    for (int n = 0; n < 5; n++) begin
      cycle();
      check("t4_wait", 32'(bus.lock_ac), 32'h0);
    end
    ul[0] = 1;
    cycle();
    check("t4_unlock", 32'(bus.lock_ac), 32'h1);
    cycle();
    check("t4_handover", 32'(bus.lock_ac), 32'h2);
    repeat (2) cycle();

    // Table full: core 1 waits until core 0 frees an entry.
    lock_op(1, 10'h3A5, 1);
    for (int a = 0; a < LOCKS; a++) lock_op(0, AW'(10'h010 + a), 0);
    lk[1] = 1; ladr[1] = 10'h020;
    for (int n = 0; n < 4; n++) begin
      cycle();
      check("t5_full", 32'(bus.lock_ac), 32'h0);
    end
    ul[0] = 1; ladr[0] = 10'h011;
    repeat (4) cycle();
    clear_inputs();
    async_reset("t5_reset");

    // Reset in the middle of memory and lock contention.
    lock_op(0, 10'h100, 0);
    lock_op(0, 10'h101, 0);
    hold_mem = 1;
    wr[0] = 1; wadr[0] = 16'h0A0A; wdat[0] = 16'h0F0F;
    wr[1] = 1; wadr[1] = 16'h0B0B; wdat[1] = 16'hF0F0;
    lk[1] = 1; ladr[1] = 10'h100;
    repeat (3) cycle();
    clear_inputs();
    lk[1] = 1; ladr[1] = 10'h100;
    async_reset("t6_reset");
    cycle();
    check("t6_relock", 32'(bus.lock_ac), 32'h2);
    repeat (2) cycle();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < C; i++) begin
        if (!rd[i] && $urandom_range(3) == 0) begin
          rd[i] = 1; radr[i] = 16'($urandom);
        end
        if (!wr[i] && $urandom_range(3) == 0) begin
          wr[i] = 1; wadr[i] = 16'($urandom); wdat[i] = 16'($urandom);
        end
        if (!lk[i] && !ul[i]) begin
          if ($urandom_range(2) == 0) begin
            ladr[i]    = pool[$urandom_range(5)];
            lk_wait[i] = 0;
            if ($urandom_range(1) == 1) ul[i] = 1;
            else                        lk[i] = 1;
          end
        end else if (lk[i] && !drop_lk[i]) begin
          lk_wait[i]++;
          if (lk_wait[i] > 6) lk[i] = 0;
        end
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
